// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Owns the PC, drives the I-cache
//               lookup address and buffers accepted instructions in a FIFO
//               that feeds decode. Optional macro FETCH_PC_OUT_EN widens the
//               FIFO entries to carry the PC and adds port dec_pc_o.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  output logic [31:0]                   icache_addr_o,
  input  logic                          icache_kabul_i,
  input  logic [31:0]                   icache_instr_i,
  input  logic                          icache_busy_i,
  input  logic                          redirect_i,
  input  logic [31:0]                   redirect_addr_i,
  output logic                          dec_valid_o,
  input  logic                          dec_ready_i,
  output logic [31:0]                   dec_instr_o,
`ifdef FETCH_PC_OUT_EN
  output logic [31:0]                   dec_pc_o,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_lvl_w = c_ptr_w + 1;
`ifdef FETCH_PC_OUT_EN
  localparam int c_entry_w = 64;
`else
  localparam int c_entry_w = 32;
`endif

  logic [31:0]          r_pc;
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_lvl_w-1:0]   r_level;
  logic [c_entry_w-1:0] r_mem [0:FIFO_DEPTH-1];

  logic                 w_full;
  logic                 w_push;
  logic                 w_pop;
  logic [c_entry_w-1:0] w_entry;
  logic [c_entry_w-1:0] w_head;
  logic                 w_unused;

  // Full comes from the registered level, so a pop never makes room for a
  // push in the same cycle.
  assign w_full  = (r_level == c_lvl_w'(FIFO_DEPTH));
  assign w_push  = icache_kabul_i && !w_full && !redirect_i;
  assign w_pop   = dec_valid_o && dec_ready_i && !redirect_i;

`ifdef FETCH_PC_OUT_EN
  assign w_entry  = {r_pc, icache_instr_i};
  assign dec_pc_o = w_head[63:32];
`else
  assign w_entry  = icache_instr_i;
`endif

  assign w_head        = r_mem[r_rd_ptr];
  assign dec_instr_o   = w_head[31:0];
  assign dec_valid_o   = (r_level != '0);
  assign icache_addr_o = r_pc;
  assign fifo_level_o  = r_level;

  // Busy is informational and the target's low bits are dropped by alignment.
  assign w_unused = &{icache_busy_i, redirect_addr_i[1:0]};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_pc     <= RESET_PC;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (redirect_i) begin
      r_pc     <= {redirect_addr_i[31:2], 2'b00};
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
        r_pc            <= r_pc + 32'd4;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_lvl_w'(1);
        2'b01:   r_level <= r_level - c_lvl_w'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit (RESET_PC=0x100,
//               FIFO_DEPTH=4); checks dec_pc_o when FETCH_PC_OUT_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  logic        clk;
  logic        reset_i;
  logic [31:0] icache_addr_o;
  logic        icache_kabul_i;
  logic [31:0] icache_instr_i;
  logic        icache_busy_i;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;
  logic        dec_valid_o;
  logic        dec_ready_i;
  logic [31:0] dec_instr_o;
`ifdef FETCH_PC_OUT_EN
  logic [31:0] dec_pc_o;
`endif
  logic [2:0]  fifo_level_o;

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(4)) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .icache_addr_o   (icache_addr_o),
    .icache_kabul_i  (icache_kabul_i),
    .icache_instr_i  (icache_instr_i),
    .icache_busy_i   (icache_busy_i),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .dec_valid_o     (dec_valid_o),
    .dec_ready_i     (dec_ready_i),
    .dec_instr_o     (dec_instr_o),
`ifdef FETCH_PC_OUT_EN
    .dec_pc_o        (dec_pc_o),
`endif
    .fifo_level_o    (fifo_level_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cache model: instruction word is a fixed scramble of its address.
  function automatic logic [31:0] ins(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, 64'(dec_valid_o), 64'd1);
    check({tag, "_instr"}, 64'(dec_instr_o), 64'(ins(pc)));
`ifdef FETCH_PC_OUT_EN
    check({tag, "_pc"}, 64'(dec_pc_o), 64'(pc));
`endif
  endtask

  // Advance one edge, settle, then present the cache word for the new PC.
  task automatic tick;
    @(posedge clk);
    #1;
    icache_instr_i = ins(icache_addr_o);
  endtask

  initial begin
    reset_i         = 1'b1;
    icache_kabul_i  = 1'b0;
    icache_instr_i  = 32'h0;
    icache_busy_i   = 1'b0;
    redirect_i      = 1'b0;
    redirect_addr_i = 32'h0;
    dec_ready_i     = 1'b0;
    tick; tick;
    check("rst_addr",  64'(icache_addr_o), 64'h100);
    check("rst_valid", 64'(dec_valid_o), 64'd0);
    check("rst_level", 64'(fifo_level_o), 64'd0);
    check("rst_instr", 64'(dec_instr_o), 64'd0);
`ifdef FETCH_PC_OUT_EN
    check("rst_pc",    64'(dec_pc_o), 64'd0);
`endif
    reset_i = 1'b0;
    tick;
    check("rel_addr", 64'(icache_addr_o), 64'h100);

    // Streaming: one instruction per cycle.
    icache_kabul_i = 1'b1;
    dec_ready_i    = 1'b1;
    tick;
    check_head("s0", 32'h100);
    check("s0_addr", 64'(icache_addr_o), 64'h104);
    tick;
    check_head("s1", 32'h104);
    check("s1_level", 64'(fifo_level_o), 64'd1);
    tick;
    check_head("s2", 32'h108);
    check("s2_addr", 64'(icache_addr_o), 64'h10C);

    // Build level 2, then redirect with a same-cycle kabul.
    dec_ready_i = 1'b0;
    tick;
    check("pre_rd_level", 64'(fifo_level_o), 64'd2);
    redirect_i      = 1'b1;
    redirect_addr_i = 32'h2003;
    dec_ready_i     = 1'b1;
    tick;
    check("rd_addr",  64'(icache_addr_o), 64'h2000);
    check("rd_level", 64'(fifo_level_o), 64'd0);
    check("rd_valid", 64'(dec_valid_o), 64'd0);

    // Back to 0x100 and fill the FIFO with decode stalled.
    redirect_addr_i = 32'h100;
    icache_kabul_i  = 1'b0;
    tick;
    redirect_i     = 1'b0;
    icache_kabul_i = 1'b1;
    dec_ready_i    = 1'b0;
    tick; tick; tick; tick;
    check("full_level", 64'(fifo_level_o), 64'd4);
    check("full_addr",  64'(icache_addr_o), 64'h110);
    tick;
    check("full_hold_addr",  64'(icache_addr_o), 64'h110);
    check("full_hold_level", 64'(fifo_level_o), 64'd4);
    check_head("full_head", 32'h100);

    // Pop while full with kabul: push must be blocked.
    dec_ready_i = 1'b1;
    tick;
    check("fpop_level", 64'(fifo_level_o), 64'd3);
    check("fpop_addr",  64'(icache_addr_o), 64'h110);
    check_head("fpop_head", 32'h104);
    icache_kabul_i = 1'b0;
    tick;
    check_head("d1", 32'h108);
    tick;
    check_head("d2", 32'h10C);
    tick;
    check("drain_valid", 64'(dec_valid_o), 64'd0);
    icache_kabul_i = 1'b1;
    tick;
    check_head("resume", 32'h110);
    check("resume_addr", 64'(icache_addr_o), 64'h114);

    // Miss: no kabul for 10 cycles.
    icache_kabul_i = 1'b0;
    icache_busy_i  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      check("miss_addr", 64'(icache_addr_o), 64'h114);
    end
    check("miss_level", 64'(fifo_level_o), 64'd0);
    icache_busy_i  = 1'b0;
    icache_kabul_i = 1'b1;
    dec_ready_i    = 1'b0;
    tick;
    check_head("miss_push", 32'h114);
    check("miss_push_level", 64'(fifo_level_o), 64'd1);
    icache_kabul_i = 1'b0;
    tick;
    check("miss_single", 64'(fifo_level_o), 64'd1);

    // PC wrap at the top of the address space.
    redirect_i      = 1'b1;
    redirect_addr_i = 32'hFFFF_FFFF;
    tick;
    redirect_i = 1'b0;
    check("wrap_pre", 64'(icache_addr_o), 64'hFFFF_FFFC);
    icache_kabul_i = 1'b1;
    tick;
    check("wrap_addr", 64'(icache_addr_o), 64'h0);
    check_head("wrap_head", 32'hFFFF_FFFC);
    tick; tick;
    check("pre_rst_level", 64'(fifo_level_o), 64'd3);
    check("pre_rst_addr",  64'(icache_addr_o), 64'h8);

    // Asynchronous reset between edges.
    #3;
    reset_i = 1'b1;
    #1;
    check("arst_addr",  64'(icache_addr_o), 64'h100);
    check("arst_level", 64'(fifo_level_o), 64'd0);
    check("arst_valid", 64'(dec_valid_o), 64'd0);
    check("arst_instr", 64'(dec_instr_o), 64'd0);
    tick;
    check("arst_hold_level", 64'(fifo_level_o), 64'd0);
    reset_i = 1'b0;
    tick;
    check_head("post_rst", 32'h100);
    check("post_rst_addr", 64'(icache_addr_o), 64'h104);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the direct-mapped instruction cache. Owns the program counter and drives the cache lookup address. Captures each instruction the cache accepts into a small FIFO, which feeds the decode stage through a valid/ready handshake. Also handles control-flow redirects from execute and applies back-pressure when decode stalls.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FIFO_DEPTH, 4, instruction FIFO entries; power of two, 2..16.

Ports:
- clk_i  in  1  single clock, all logic on rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- icache_addr_o  out  32  lookup address to the cache; equals PC.
- icache_kabul_i  in  1  cache accepted address on icache_addr_o this cycle (hit), instruction valid.
- icache_instr_i  in  32  instruction for icache_addr_o; valid only with icache_kabul_i.
- icache_busy_i  in  1  cache is servicing a miss.
- redirect_i  in  1  redirect request from execute (branch/jump/trap).
- redirect_addr_i  in  32  redirect target.
- dec_valid_o  out  1  FIFO head valid.
- dec_ready_i  in  1  decode consumes head when dec_valid_o && dec_ready_i.
- dec_instr_o  out  32  FIFO head instruction.
- dec_pc_o  out  32  FIFO head PC (only with FETCH_PC_OUT_EN).
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current occupancy.

## Operation
- PC register drives icache_addr_o combinationally; PC is held stable until the cache accepts it, a redirect occurs, or reset.
- Accept: icache_kabul_i && !full && !redirect_i → push {PC, icache_instr_i}, PC <= PC + 4 (wraps 32'hFFFF_FFFC → 0).
- FIFO full: icache_kabul_i is ignored, PC held; the same address is re-presented and re-accepted once space frees.
- Simultaneous push and pop while full: not allowed. Full blocks the push regardless of pop (full computed from registered level).
- Simultaneous push and pop while non-full: level unchanged, both happen.
- Pop: dec_valid_o && dec_ready_i → head advances, level - 1.
- Redirect (highest priority): PC <= {redirect_addr_i[31:2], 2'b00}; FIFO flushed (level 0, pointers 0); same-cycle kabul and pop discarded. Next cycle presents the new PC.
- icache_busy_i: informational only; PC is held naturally since no kabul arrives. It does not gate redirect, so a redirect mid-miss changes the address. The cache's miss sequence completes on the old address and is then re-looked-up at the new one.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Level saturates at FIFO_DEPTH by construction.

## Timing
- Reset (asynchronous assert, synchronous release on clock): PC = RESET_PC, icache_addr_o = RESET_PC, dec_valid_o = 0, dec_instr_o = 0, dec_pc_o = 0, fifo_level_o = 0.
- Reset mid-operation discards all FIFO contents and any accept in that cycle.
- Kabul at cycle N → entry visible on dec_valid_o in cycle N+1; icache_addr_o = PC+4 in cycle N+1.
- Throughput: one instruction per cycle on consecutive hits with decode ready.
- Redirect at cycle N → icache_addr_o = target and dec_valid_o = 0 in cycle N+1.
- dec_instr_o/dec_pc_o read from the registered FIFO array and are stable while dec_valid_o && !dec_ready_i.

## Configuration
- FETCH_PC_OUT_EN defined: FIFO entries are 64 bits ({pc, instr}); port dec_pc_o is present and carries the head PC.
- FETCH_PC_OUT_EN undefined: FIFO entries are 32 bits; dec_pc_o port is absent; all other behaviour identical.

## Test plan
- Reset with RESET_PC=32'h100 → icache_addr_o=32'h100, dec_valid_o=0, level 0; release; kabul every cycle, dec_ready_i=1 → dec_instr_o follows pushed values one cycle later, addresses 100,104,108.
- dec_ready_i=0, kabul every cycle, FIFO_DEPTH=4 → level reaches 4 after 4 accepts, icache_addr_o holds at 32'h110; raise dec_ready_i → 4 pops in order, then streaming resumes at 32'h110.
- Level 2, redirect_i with redirect_addr_i=32'h2003 and kabul same cycle → next cycle icache_addr_o=32'h2000, level 0, dec_valid_o=0, nothing pushed.
- Kabul never asserted for 10 cycles (miss, icache_busy_i=1) → icache_addr_o stable, level unchanged; kabul then → single push.
- PC=32'hFFFF_FFFC, kabul → next PC=32'h0000_0000.
- Assert reset_i asynchronously mid-stream between clock edges with level 3 → outputs reach reset values before next edge; FETCH_PC_OUT_EN build checks dec_pc_o matches pushed PCs throughout.
